// File: rtl/morse_pkg.sv
// Shared Morse symbol constants and helpers for the sequence queue front end.
package morse_pkg;

  localparam logic [1:0] SYM_DOT   = 2'b00;
  localparam logic [1:0] SYM_DASH  = 2'b01;
  localparam logic [1:0] SYM_SPACE = 2'b10;
  localparam logic [1:0] SYM_EMPTY = 2'b11;

  // A sequence is empty when its first (MSB) symbol is the pad code.
  function automatic logic seq_is_empty(input logic [1:0] head_sym);
    return head_sym == SYM_EMPTY;
  endfunction

endpackage

// File: rtl/seq_fifo_2w1r.sv
// Circular queue with two ordered write ports (port 0 lands first) and one
// first-word-fall-through read port; reads all ones while empty.
module seq_fifo_2w1r #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr0_en_i,
  input  logic [W-1:0]  wr0_data_i,
  input  logic          wr1_en_i,
  input  logic [W-1:0]  wr1_data_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          rd_valid_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr1_ptr;
  logic          pop;
  logic [CW-1:0] n_push;

  always_comb begin
    pop     = rd_en_i && (count_q != '0);
    n_push  = CW'(wr0_en_i) + CW'(wr1_en_i);
    wr1_ptr = wr0_en_i ? wptr_q + AW'(1) : wptr_q;
    wptr_d  = wptr_q + AW'(n_push);
    rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + n_push - CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset: the empty flag masks stale contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr0_en_i) mem_q[wptr_q] <= wr0_data_i;
    if (!rst_i && wr1_en_i) mem_q[wr1_ptr] <= wr1_data_i;
  end

  assign rd_valid_o = (count_q != '0);
  assign rd_data_o  = rd_valid_o ? mem_q[rptr_q] : '1;
  assign count_o    = count_q;

endmodule

// File: rtl/morse_seq_queue.sv
// Splits each sent_flag event into sequence/space entries and queues them for
// the decoder. Handshake: an entry transfers on any edge where out_valid && out_ready.
module morse_seq_queue
  import morse_pkg::*;
#(
  parameter int SYM_MAX         = 5,
  parameter int DEPTH           = 8,
  parameter bit COLLAPSE_SPACES = 1'b1,
  localparam int W              = 2 * SYM_MAX,
  localparam int CW             = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  enc_seq,
  input  logic          space_endseqbar,
  input  logic          sent_flag,
  output logic [W-1:0]  out_seq,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          event_done,
  output logic          overflow,
  output logic [CW-1:0] count
);

  localparam logic [W-1:0] SPACE_ENTRY = {SYM_SPACE, {(W-2){1'b1}}};

  logic          last_was_space_q, last_was_space_d;
  logic          event_done_q;
  logic          overflow_q, overflow_d;
  logic          want_seq, want_space, drop, accept;
  logic [1:0]    req;
  logic [CW-1:0] free_slots;
  logic          wr0_en, wr1_en;
  logic [W-1:0]  wr0_data;

  always_comb begin
    want_seq   = sent_flag && !seq_is_empty(enc_seq[W-1 -: 2]);
    // A lone space right after another space (or after reset) is swallowed.
    want_space = sent_flag && space_endseqbar &&
                 !(COLLAPSE_SPACES && last_was_space_q && !want_seq);
    req        = {1'b0, want_seq} + {1'b0, want_space};
    // Free space is judged before this cycle's pop, so a pop never rescues a full queue.
    free_slots = CW'(DEPTH) - count;
    drop       = CW'(req) > free_slots;
    accept     = !drop;

    wr0_en     = accept && (want_seq || want_space);
    wr0_data   = want_seq ? enc_seq : SPACE_ENTRY;
    wr1_en     = accept && want_seq && want_space;

    last_was_space_d = last_was_space_q;
    if (accept && want_space)     last_was_space_d = 1'b1;
    else if (accept && want_seq)  last_was_space_d = 1'b0;

    overflow_d = drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_was_space_q <= 1'b1;
      event_done_q     <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      last_was_space_q <= last_was_space_d;
      event_done_q     <= sent_flag;
      overflow_q       <= overflow_d;
    end
  end

  seq_fifo_2w1r #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr0_en_i   (wr0_en),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (wr1_en),
    .wr1_data_i (SPACE_ENTRY),
    .rd_en_i    (out_valid && out_ready),
    .rd_data_o  (out_seq),
    .rd_valid_o (out_valid),
    .count_o    (count)
  );

  assign event_done = event_done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_morse_seq_queue.sv
// Bench for morse_seq_queue: three configurations share one stimulus stream and
// are compared every cycle against a queue-based reference model.
module tb_morse_seq_queue;

  localparam int W = 10;
  localparam logic [W-1:0] SPACE_E = 10'b1011111111;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] enc_seq = '1;
  logic         space_endseqbar = 1'b0;
  logic         sent_flag = 1'b0;
  logic         out_ready = 1'b0;

  logic [W-1:0] out_seq_w    [3];
  logic         out_valid_w  [3];
  logic         event_done_w [3];
  logic         overflow_w   [3];
  logic [3:0]   count_w      [3];
  logic [3:0]   count0, count2;
  logic [2:0]   count1;

  int passed = 0;
  int total  = 0;

  logic [W-1:0] exp_q [3][$];
  bit           lws   [3];
  bit           exp_ed[3];
  bit           exp_ov[3];
  int           dep_a [3];
  bit           col_a [3];

  always #5 clk = ~clk;

  morse_seq_queue #(.SYM_MAX(5), .DEPTH(8), .COLLAPSE_SPACES(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .enc_seq(enc_seq), .space_endseqbar(space_endseqbar),
    .sent_flag(sent_flag), .out_seq(out_seq_w[0]), .out_valid(out_valid_w[0]),
    .out_ready(out_ready), .event_done(event_done_w[0]), .overflow(overflow_w[0]),
    .count(count0));

  morse_seq_queue #(.SYM_MAX(5), .DEPTH(4), .COLLAPSE_SPACES(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .enc_seq(enc_seq), .space_endseqbar(space_endseqbar),
    .sent_flag(sent_flag), .out_seq(out_seq_w[1]), .out_valid(out_valid_w[1]),
    .out_ready(out_ready), .event_done(event_done_w[1]), .overflow(overflow_w[1]),
    .count(count1));

  morse_seq_queue #(.SYM_MAX(5), .DEPTH(8), .COLLAPSE_SPACES(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .enc_seq(enc_seq), .space_endseqbar(space_endseqbar),
    .sent_flag(sent_flag), .out_seq(out_seq_w[2]), .out_valid(out_valid_w[2]),
    .out_ready(out_ready), .event_done(event_done_w[2]), .overflow(overflow_w[2]),
    .count(count2));

  assign count_w[0] = count0;
  assign count_w[1] = {1'b0, count1};
  assign count_w[2] = count2;

  task automatic chk(input string tag, input int inst, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[dut%0d]: got %0h expected %0h", tag, inst, obs, exp);
  endtask

  // Reference: one edge of the queue as described by the event rules.
  task automatic model_edge(input logic r, input logic s, input logic [W-1:0] e,
                            input logic sp, input logic rdy);
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] ent[$];
      int free;
      if (r) begin
        exp_q[i].delete();
        lws[i] = 1'b1; exp_ed[i] = 1'b0; exp_ov[i] = 1'b0;
        continue;
      end
      free = dep_a[i] - exp_q[i].size();
      exp_ed[i] = s;
      exp_ov[i] = 1'b0;
      if (exp_q[i].size() > 0 && rdy) void'(exp_q[i].pop_front());
      if (s) begin
        if (e[W-1:W-2] != 2'b11) ent.push_back(e);
        if (sp && !(col_a[i] && lws[i] && ent.size() == 0)) ent.push_back(SPACE_E);
        if (ent.size() > free) exp_ov[i] = 1'b1;
        else begin
          foreach (ent[k]) exp_q[i].push_back(ent[k]);
          if (ent.size() > 0) lws[i] = (ent[ent.size()-1] == SPACE_E);
        end
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 3; i++) begin
      chk("count", i, 16'(count_w[i]), 16'(exp_q[i].size()));
      chk("out_valid", i, 16'(out_valid_w[i]), 16'(exp_q[i].size() > 0));
      chk("out_seq", i, 16'(out_seq_w[i]),
          16'((exp_q[i].size() > 0) ? exp_q[i][0] : 10'h3FF));
      chk("event_done", i, 16'(event_done_w[i]), 16'(exp_ed[i]));
      chk("overflow", i, 16'(overflow_w[i]), 16'(exp_ov[i]));
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [W-1:0] e,
                      input logic sp, input logic rdy);
    rst = r; sent_flag = s; enc_seq = e; space_endseqbar = sp; out_ready = rdy;
    @(posedge clk);
    model_edge(r, s, e, sp, rdy);
    #1;
    check_model();
  endtask

  initial begin
    dep_a = '{8, 4, 8};
    col_a = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) lws[i] = 1'b1;

    // Reset state
    step(1, 0, '1, 0, 0);
    step(1, 0, '1, 0, 0);
    chk("rst_count", 0, 16'(count0), 16'd0);
    chk("rst_seq", 0, 16'(out_seq_w[0]), 16'h3FF);
    chk("rst_valid", 0, 16'(out_valid_w[0]), 16'd0);

    // EndSeq dot-dash, then pop it
    step(0, 1, 10'b0001111111, 0, 0);
    chk("endseq_seq", 0, 16'(out_seq_w[0]), 16'h07F);
    chk("endseq_count", 0, 16'(count0), 16'd1);
    chk("endseq_done", 0, 16'(event_done_w[0]), 16'd1);
    step(0, 0, '1, 0, 1);
    chk("pop_count", 0, 16'(count0), 16'd0);
    chk("pop_seq", 0, 16'(out_seq_w[0]), 16'h3FF);

    // Space with a sequence: sequence first, then the space entry
    step(0, 1, 10'b0000001111, 1, 0);
    chk("dbl_count", 0, 16'(count0), 16'd2);
    chk("dbl_head0", 0, 16'(out_seq_w[0]), 16'h00F);
    step(0, 0, '1, 0, 0);
    chk("dbl_hold", 0, 16'(out_seq_w[0]), 16'h00F);
    step(0, 0, '1, 0, 1);
    chk("dbl_head1", 0, 16'(out_seq_w[0]), 16'h2FF);
    step(0, 0, '1, 0, 1);

    // Leading space suppressed after reset
    step(1, 0, '1, 0, 0);
    step(0, 1, '1, 1, 0);
    chk("lead_count", 0, 16'(count0), 16'd0);
    chk("lead_done", 0, 16'(event_done_w[0]), 16'd1);

    // Seq, space, space: collapse gives 2, no-collapse gives 3
    step(1, 0, '1, 0, 0);
    step(0, 1, 10'b0101111111, 0, 0);
    step(0, 1, '1, 1, 0);
    step(0, 1, '1, 1, 0);
    chk("col_count", 0, 16'(count0), 16'd2);
    chk("nocol_count", 2, 16'(count2), 16'd3);

    // Overflow on the DEPTH=4 instance
    step(1, 0, '1, 0, 0);
    step(0, 1, 10'b0001111111, 0, 0);
    step(0, 1, 10'b0111111111, 0, 0);
    step(0, 1, 10'b0100111111, 0, 0);
    chk("fill_count", 1, 16'(count1), 16'd3);
    step(0, 1, 10'b0000001111, 1, 0);
    chk("drop_count", 1, 16'(count1), 16'd3);
    chk("drop_ovf", 1, 16'(overflow_w[1]), 16'd1);
    step(0, 0, '1, 0, 0);
    chk("ovf_once", 1, 16'(overflow_w[1]), 16'd0);
    step(0, 1, 10'b0011111111, 0, 0);
    chk("full_count", 1, 16'(count1), 16'd4);
    step(0, 1, 10'b0001011111, 0, 1);
    chk("prepop_count", 1, 16'(count1), 16'd3);
    chk("prepop_ovf", 1, 16'(overflow_w[1]), 16'd1);

    // Reset beats a simultaneous event
    step(1, 1, 10'b0001111111, 0, 1);
    chk("rstpri_count", 0, 16'(count0), 16'd0);
    chk("rstpri_valid", 0, 16'(out_valid_w[0]), 16'd0);
    chk("rstpri_done", 0, 16'(event_done_w[0]), 16'd0);
    step(0, 1, '1, 1, 0);
    chk("rst_lead_count", 0, 16'(count0), 16'd0);

    // Random traffic: slow drain first, then fast drain
    for (int n = 0; n < 400; n++) begin
      logic r, s, sp, rdy;
      logic [W-1:0] e;
      r   = ($urandom_range(0, 63) == 0);
      s   = $urandom_range(0, 1) == 1;
      e   = W'($urandom);
      sp  = $urandom_range(0, 1) == 1;
      rdy = (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(r, s, e, sp, rdy);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
